// File: rtl/except_sched_pkg.sv
// except_sched shared definitions
// exception codes, flag bit indices and FSM states
package except_sched_pkg;

    localparam int IRQ_W = 6;

    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    localparam int EXC_BIT_SYSCALL = 0;
    localparam int EXC_BIT_INVALID = 1;
    localparam int EXC_BIT_TRAP    = 2;
    localparam int EXC_BIT_OV      = 3;
    localparam int EXC_BIT_ERET    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/except_sched_irq_sync.sv
// irq_sync: two-flop synchroniser for the
// external interrupt lines
module irq_sync
    import except_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] d,
    output logic [IRQ_W-1:0] q
);

    logic [IRQ_W-1:0] meta_q;

    // two stages to settle metastability on async lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/except_sched.sv
// except_sched: picks the winning exception for MEM,
// drives CP0 excepttype and sequences flush/redirect
module except_sched
    import except_sched_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          BLANK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] int_i,
    input  logic             mem_valid_i,
    input  logic [31:0]      mem_pc_i,
    input  logic             mem_in_delayslot_i,
    input  logic [4:0]       mem_exc_i,
    input  logic [31:0]      status_i,
    input  logic [31:0]      cause_i,
    input  logic [31:0]      epc_i,
    output logic [IRQ_W-1:0] irq_sync_o,
    output logic [31:0]      excepttype_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             busy_o,
    output logic [15:0]      exc_count_o
);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [15:0] count_q;
    logic [15:0] exc_count_q;
    logic [31:0] code;
    logic        int_pend;
    logic        cand;

    // PC and delay-slot flag go to CP0 directly
    logic unused_ok;
    assign unused_ok = ^{mem_pc_i, mem_in_delayslot_i,
                         cause_i[31:16], cause_i[7:0],
                         status_i[31:16], status_i[7:2]};

    irq_sync u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d   (int_i),
        .q   (irq_sync_o)
    );

    assign int_pend = status_i[0] & ~status_i[1] &
                      (|(cause_i[15:8] & status_i[15:8]));

    // reset forces the code to zero even though IDLE
    assign cand = rst & (state_q == IDLE) & mem_valid_i &
                  (int_pend | (|mem_exc_i));

    // fixed-priority pick of the event code
    always_comb begin
        code = '0;
        if (int_pend)
            code = EXC_INT;
        else if (mem_exc_i[EXC_BIT_SYSCALL])
            code = EXC_SYSCALL;
        else if (mem_exc_i[EXC_BIT_INVALID])
            code = EXC_INST_INVALID;
        else if (mem_exc_i[EXC_BIT_TRAP])
            code = EXC_TRAP;
        else if (mem_exc_i[EXC_BIT_OV])
            code = EXC_OV;
        else if (mem_exc_i[EXC_BIT_ERET])
            code = EXC_ERET;
    end

    assign excepttype_o = cand ? code : '0;

    // next-state, blank counter and redirect target
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (cand) begin
                    state_d = FLUSH;
                    pc_d    = (code == EXC_ERET) ? epc_i
                                                 : EXC_VECTOR;
                end
            end
            FLUSH: begin
                state_d = BLANK;
                cnt_d   = 3'(BLANK_CYCLES - 1);
            end
            BLANK: begin
                if (cnt_q == 3'd0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counter and target registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    // saturating count of accepted events
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            exc_count_q <= '0;
        else if (cand && exc_count_q != 16'hFFFF)
            exc_count_q <= exc_count_q + 16'd1;
    end

    assign count_q     = exc_count_q;
    assign exc_count_o = count_q;
    assign flush_o     = (state_q == FLUSH);
    assign busy_o      = (state_q != IDLE);
    assign new_pc_o    = pc_q;

endmodule
